// File: rtl/cp_lsu_pipe.sv
// rtl/cp_lsu_pipe.sv - CP load/store unit: address gen, DMEM request stage, load queue, load extraction
//
// Purpose: computes A+B byte addresses, issues aligned DMEM requests through a single registered
// stage with valid/ready backpressure, tracks outstanding loads in an in-order metadata queue and
// extracts/extends returned load data for writeback.
// Optional feature: define DEF_CP_LSU_MISALIGN_TRAP_EN to trap misaligned accesses (oMisalign pulse)
// instead of silently aligning them down to the access size.
// Ports:
//   iClk, iReset (async, active-low)
//   iReq_Valid/oReq_Ready, iOperand_A/B, iWrite_Enable, iRead_Enable, iOpcode, iSigned, iStore_Data
//                                                                   request side from ID/EX
//   oDMEM_Valid/iDMEM_Ready, oDMEM_Write_Enable, oDMEM_Read_Enable, oDMEM_Byte_Select,
//   oDMEM_Address, oDMEM_Store_Data                                 DMEM request port
//   iDMEM_Read_Valid, iDMEM_Read_Data                               in-order DMEM load response
//   oLoad_Valid, oLoad_Data                                         load result to writeback
//   oMisalign, oMisalign_Address                                    misalignment trap
module cp_lsu_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LDQ_DEPTH  = 2
) (
    input  logic                    iClk,
    input  logic                    iReset,
    input  logic                    iReq_Valid,
    output logic                    oReq_Ready,
    input  logic [DATA_WIDTH-1:0]   iOperand_A,
    input  logic [DATA_WIDTH-1:0]   iOperand_B,
    input  logic                    iWrite_Enable,
    input  logic                    iRead_Enable,
    input  logic [1:0]              iOpcode,
    input  logic                    iSigned,
    input  logic [DATA_WIDTH-1:0]   iStore_Data,
    output logic                    oDMEM_Valid,
    input  logic                    iDMEM_Ready,
    output logic                    oDMEM_Write_Enable,
    output logic                    oDMEM_Read_Enable,
    output logic [DATA_WIDTH/8-1:0] oDMEM_Byte_Select,
    output logic [ADDR_WIDTH-1:0]   oDMEM_Address,
    output logic [DATA_WIDTH-1:0]   oDMEM_Store_Data,
    input  logic                    iDMEM_Read_Valid,
    input  logic [DATA_WIDTH-1:0]   iDMEM_Read_Data,
    output logic                    oLoad_Valid,
    output logic [DATA_WIDTH-1:0]   oLoad_Data,
    output logic                    oMisalign,
    output logic [ADDR_WIDTH-1:0]   oMisalign_Address
);
    localparam int NB   = DATA_WIDTH / 8;
    localparam int OFFW = (NB > 1) ? $clog2(NB) : 1;
    localparam int PTRW = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int CNTW = $clog2(LDQ_DEPTH + 1);

    typedef struct packed {
        logic [OFFW-1:0] laneOff;
        logic [1:0]      sizeLog;
        logic            isSigned;
    } ldqEntry_t;

    ldqEntry_t             ldq [LDQ_DEPTH];
    ldqEntry_t             head;
    logic [PTRW-1:0]       wrPtr, rdPtr;
    logic [CNTW-1:0]       loadCnt;

    logic [ADDR_WIDTH-1:0] addrSum, alignedAddr;
    logic [3:0]            sizeBytes;
    logic [2:0]            lowMask;
    logic [OFFW-1:0]       laneOff;
    logic                  isStore, isLoad, memOp, opInvalid, trapHit;
    logic                  accept, issue, push, pop;
    logic [NB-1:0]         byteSel;
    logic [DATA_WIDTH-1:0] storeRep, shifted, extended;
    logic [63:0]           wide;
    logic [5:0]            topBit;
    logic                  signBit;

    function automatic logic [PTRW-1:0] nextPtr(input logic [PTRW-1:0] p);
        return (p == PTRW'(LDQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Address generation and decode
    assign addrSum     = ADDR_WIDTH'(iOperand_A + iOperand_B);
    assign sizeBytes   = 4'd1 << iOpcode;
    assign lowMask     = 3'(sizeBytes - 4'd1);
    assign alignedAddr = {addrSum[ADDR_WIDTH-1:3], addrSum[2:0] & ~lowMask};
    assign laneOff     = alignedAddr[OFFW-1:0];
    // Store has priority when both enables are raised
    assign isStore     = iWrite_Enable;
    assign isLoad      = iRead_Enable && !iWrite_Enable;
    assign memOp       = isStore || isLoad;
    assign opInvalid   = (DATA_WIDTH == 32) && (iOpcode == 2'b11);

`ifdef DEF_CP_LSU_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(addrSum[2:0] & lowMask);
    assign trapHit    = misaligned;
`else
    assign trapHit    = 1'b0;
`endif

    // Full queue stalls every request, stores included, to keep issue in order
    assign oReq_Ready = (!oDMEM_Valid || iDMEM_Ready) && (loadCnt < CNTW'(LDQ_DEPTH));
    assign accept     = iReq_Valid && oReq_Ready;
    assign issue      = accept && memOp && !opInvalid && !trapHit;
    assign push       = issue && isLoad;
    assign pop        = iDMEM_Read_Valid && (loadCnt != '0);

    // Byte lanes and store-data replication (element repeated in every S-byte slot)
    always_comb begin
        byteSel  = '0;
        storeRep = '0;
        for (int i = 0; i < NB; i++) begin
            byteSel[i] = (i >= int'(laneOff)) && (i < int'(laneOff) + int'(sizeBytes));
            storeRep[8*i +: 8] = iStore_Data[8*(i & (int'(sizeBytes) - 1)) +: 8];
        end
    end

    // DMEM request stage
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oDMEM_Valid        <= 1'b0;
            oDMEM_Write_Enable <= 1'b0;
            oDMEM_Read_Enable  <= 1'b0;
            oDMEM_Byte_Select  <= '0;
            oDMEM_Address      <= '0;
            oDMEM_Store_Data   <= '0;
        end else if (accept) begin
            oDMEM_Valid        <= issue;
            oDMEM_Write_Enable <= issue && isStore;
            oDMEM_Read_Enable  <= issue && isLoad;
            oDMEM_Byte_Select  <= issue ? byteSel : '0;
            oDMEM_Address      <= issue ? alignedAddr : '0;
            oDMEM_Store_Data   <= issue ? storeRep : '0;
        end else if (oDMEM_Valid && iDMEM_Ready) begin
            oDMEM_Valid        <= 1'b0;
            oDMEM_Write_Enable <= 1'b0;
            oDMEM_Read_Enable  <= 1'b0;
            oDMEM_Byte_Select  <= '0;
            oDMEM_Address      <= '0;
            oDMEM_Store_Data   <= '0;
        end
    end

    // Load metadata queue: entry storage needs no reset, pointers and count do
    always_ff @(posedge iClk) begin
        if (push) begin
            ldq[wrPtr] <= '{laneOff: laneOff, sizeLog: iOpcode, isSigned: iSigned};
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            loadCnt <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      loadCnt <= loadCnt + 1'b1;
            else if (pop && !push) loadCnt <= loadCnt - 1'b1;
        end
    end

    // Load extraction: shift element to LSBs, then extend above its top bit
    assign head    = ldq[rdPtr];
    assign shifted = iDMEM_Read_Data >> {head.laneOff, 3'b000};
    assign wide    = 64'(shifted);
    assign topBit  = 6'((7'd8 << head.sizeLog) - 7'd1);
    assign signBit = wide[topBit];

    always_comb begin
        extended = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            extended[i] = (i <= int'(topBit)) ? shifted[i] : (head.isSigned & signBit);
        end
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oLoad_Valid <= 1'b0;
            oLoad_Data  <= '0;
        end else begin
            oLoad_Valid <= pop;
            if (pop) oLoad_Data <= extended;
        end
    end

`ifdef DEF_CP_LSU_MISALIGN_TRAP_EN
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oMisalign         <= 1'b0;
            oMisalign_Address <= '0;
        end else begin
            oMisalign <= accept && memOp && !opInvalid && misaligned;
            if (accept && memOp && !opInvalid && misaligned) oMisalign_Address <= addrSum;
        end
    end
`else
    assign oMisalign         = 1'b0;
    assign oMisalign_Address = '0;
`endif

endmodule

// File: tb/tb_cp_lsu_pipe.sv
// tb/tb_cp_lsu_pipe.sv - randomized self-checking bench for cp_lsu_pipe with reference model
module tb_cp_lsu_pipe;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 2;
    localparam int NB    = DW / 8;

    logic          iClk = 1'b0;
    logic          iReset = 1'b0;
    logic          iReq_Valid = 1'b0;
    logic          oReq_Ready;
    logic [DW-1:0] iOperand_A = '0;
    logic [DW-1:0] iOperand_B = '0;
    logic          iWrite_Enable = 1'b0;
    logic          iRead_Enable = 1'b0;
    logic [1:0]    iOpcode = '0;
    logic          iSigned = 1'b0;
    logic [DW-1:0] iStore_Data = '0;
    logic          oDMEM_Valid;
    logic          iDMEM_Ready = 1'b0;
    logic          oDMEM_Write_Enable;
    logic          oDMEM_Read_Enable;
    logic [NB-1:0] oDMEM_Byte_Select;
    logic [AW-1:0] oDMEM_Address;
    logic [DW-1:0] oDMEM_Store_Data;
    logic          iDMEM_Read_Valid = 1'b0;
    logic [DW-1:0] iDMEM_Read_Data = '0;
    logic          oLoad_Valid;
    logic [DW-1:0] oLoad_Data;
    logic          oMisalign;
    logic [AW-1:0] oMisalign_Address;

    cp_lsu_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LDQ_DEPTH(DEPTH)) dut (
        .iClk(iClk), .iReset(iReset),
        .iReq_Valid(iReq_Valid), .oReq_Ready(oReq_Ready),
        .iOperand_A(iOperand_A), .iOperand_B(iOperand_B),
        .iWrite_Enable(iWrite_Enable), .iRead_Enable(iRead_Enable),
        .iOpcode(iOpcode), .iSigned(iSigned), .iStore_Data(iStore_Data),
        .oDMEM_Valid(oDMEM_Valid), .iDMEM_Ready(iDMEM_Ready),
        .oDMEM_Write_Enable(oDMEM_Write_Enable), .oDMEM_Read_Enable(oDMEM_Read_Enable),
        .oDMEM_Byte_Select(oDMEM_Byte_Select), .oDMEM_Address(oDMEM_Address),
        .oDMEM_Store_Data(oDMEM_Store_Data),
        .iDMEM_Read_Valid(iDMEM_Read_Valid), .iDMEM_Read_Data(iDMEM_Read_Data),
        .oLoad_Valid(oLoad_Valid), .oLoad_Data(oLoad_Data),
        .oMisalign(oMisalign), .oMisalign_Address(oMisalign_Address)
    );

    always #5 iClk = ~iClk;

    int compared   = 0;
    int mismatched = 0;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: pending DMEM request, queue of outstanding loads, expected results
    typedef struct {
        int lane;
        int size;
        bit sgn;
    } ldEnt_t;

    ldEnt_t        ldq[$];
    int            issuedOut;
    bit            mValid, mWe, mRe;
    logic [NB-1:0] mBs;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mSd;
    bit            mLdValid;
    logic [DW-1:0] mLdData;
    bit            mMis;
    logic [AW-1:0] mMisAddr;

    task automatic clearReq();
        mValid = 0; mWe = 0; mRe = 0; mBs = '0; mAddr = '0; mSd = '0;
    endtask

    task automatic modelClear();
        clearReq();
        ldq.delete();
        issuedOut = 0;
        mLdValid = 0; mLdData = '0; mMis = 0; mMisAddr = '0;
    endtask

    task automatic checkOutputs();
        checkVal("dmem_valid", oDMEM_Valid, mValid);
        checkVal("dmem_we", oDMEM_Write_Enable, mWe);
        checkVal("dmem_re", oDMEM_Read_Enable, mRe);
        checkVal("dmem_bs", oDMEM_Byte_Select, mBs);
        checkVal("dmem_addr", oDMEM_Address, mAddr);
        checkVal("dmem_sdata", oDMEM_Store_Data, mSd);
        checkVal("load_valid", oLoad_Valid, mLdValid);
        checkVal("load_data", oLoad_Data, mLdData);
        checkVal("misalign", oMisalign, mMis);
        checkVal("misalign_addr", oMisalign_Address, mMisAddr);
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1
    task automatic step();
        bit            rdy, acc, hs, isSt, isLd, inv, mis, trap, issue, misHit;
        logic [AW-1:0] addr;
        int            size, lane;
        logic [63:0]   v, m;
        ldEnt_t        e;
        #1;
        rdy = (!mValid || iDMEM_Ready) && (ldq.size() < DEPTH);
        checkVal("req_ready", oReq_Ready, rdy);
        acc = iReq_Valid && rdy;
        hs  = mValid && iDMEM_Ready;
        mLdValid = 0;
        if (iDMEM_Read_Valid && ldq.size() > 0) begin
            e = ldq.pop_front();
            v = 64'(iDMEM_Read_Data) >> (8 * e.lane);
            m = (e.size == 8) ? '1 : ((64'd1 << (8 * e.size)) - 64'd1);
            v = v & m;
            if (e.sgn && v[8*e.size-1]) v = v | ~m;
            mLdValid = 1;
            mLdData  = v[DW-1:0];
            issuedOut--;
        end
        if (hs && mRe) issuedOut++;
        addr = AW'(iOperand_A + iOperand_B);
        size = 1 << iOpcode;
        isSt = iWrite_Enable;
        isLd = iRead_Enable && !iWrite_Enable;
        inv  = (iOpcode == 2'd3) && (DW == 32);
        mis  = (addr % AW'(size)) != 0;
        trap = 0;
`ifdef DEF_CP_LSU_MISALIGN_TRAP_EN
        trap = mis;
`endif
        issue  = acc && (isSt || isLd) && !inv && !trap;
        misHit = acc && (isSt || isLd) && !inv && trap;
        if (issue) begin
            mValid = 1; mWe = isSt; mRe = isLd;
            mAddr  = addr - (addr % AW'(size));
            lane   = int'(mAddr % AW'(NB));
            mBs    = NB'(((1 << size) - 1) << lane);
            for (int i = 0; i < NB; i++) mSd[8*i +: 8] = iStore_Data[8*(i % size) +: 8];
            if (isLd) ldq.push_back('{lane, size, iSigned});
        end else if (acc || hs) begin
            clearReq();
        end
        mMis = misHit;
        if (misHit) mMisAddr = addr;
        @(posedge iClk);
        #1;
        checkOutputs();
    endtask

    task automatic cyc(input bit rv, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input bit we, input bit re, input logic [1:0] op, input bit sg,
                       input logic [DW-1:0] sd, input bit dr, input bit rdv, input logic [DW-1:0] rd);
        iReq_Valid = rv; iOperand_A = a; iOperand_B = b; iWrite_Enable = we; iRead_Enable = re;
        iOpcode = op; iSigned = sg; iStore_Data = sd; iDMEM_Ready = dr;
        iDMEM_Read_Valid = rdv; iDMEM_Read_Data = rd;
        step();
    endtask

    task automatic idle(input bit dr, input bit rdv, input logic [DW-1:0] rd);
        cyc(0, '0, '0, 0, 0, 2'd0, 0, '0, dr, rdv, rd);
    endtask

    task automatic midReset();
        iReq_Valid = 0; iDMEM_Read_Valid = 0;
        #2;
        iReset = 0;
        #1;
        modelClear();
        checkOutputs();
        @(posedge iClk);
        #1;
        iReset = 1;
    endtask

    initial begin
        bit            rv, we, re, sg, dr, rdv;
        logic [1:0]    op;
        logic [DW-1:0] a, b, sd, rd;

        modelClear();
        repeat (3) @(posedge iClk);
        #1;
        checkOutputs();
        iReset = 1;

        // Store word 0x100+4
        cyc(1, 32'h100, 32'h4, 1, 0, 2'd2, 0, 32'h11223344, 1, 0, '0);
        checkVal("sw_addr", oDMEM_Address, 32'h104);
        checkVal("sw_bs", oDMEM_Byte_Select, 4'b1111);
        checkVal("sw_valid", oDMEM_Valid, 1);
        idle(1, 0, '0);
        checkVal("sw_valid_drop", oDMEM_Valid, 0);

        // Store byte at 0x103
        cyc(1, 32'h103, 32'h0, 1, 0, 2'd0, 0, 32'hAB, 1, 0, '0);
        checkVal("sb_bs", oDMEM_Byte_Select, 4'b1000);
        checkVal("sb_sdata", oDMEM_Store_Data, 32'hABABABAB);
        idle(1, 0, '0);

        // Load half signed at 0x2
        cyc(1, 32'h2, 32'h0, 0, 1, 2'd1, 1, '0, 1, 0, '0);
        idle(1, 0, '0);
        idle(1, 1, 32'h8001_0000);
        checkVal("lh_valid", oLoad_Valid, 1);
        checkVal("lh_data", oLoad_Data, 32'hFFFF8001);
        idle(1, 0, '0);
        checkVal("lh_valid_pulse", oLoad_Valid, 0);

        // Queue full, then simultaneous push/pop
        cyc(1, 32'h0, 32'h0, 0, 1, 2'd2, 0, '0, 1, 0, '0);
        cyc(1, 32'h4, 32'h0, 0, 1, 2'd2, 0, '0, 1, 0, '0);
        idle(1, 0, '0);
        checkVal("full_ready", oReq_Ready, 0);
        cyc(1, 32'h8, 32'h0, 0, 1, 2'd2, 0, '0, 1, 1, 32'h1234_5678);
        cyc(1, 32'h8, 32'h0, 0, 1, 2'd0, 1, '0, 1, 1, 32'h0000_0080);
        idle(1, 0, '0);
        idle(1, 1, 32'hDEAD_BEEF);
        checkVal("pushpop_data", oLoad_Data, 32'hFFFFFFEF);

        // DMEM backpressure for 3 cycles
        cyc(1, 32'h20, 32'h0, 1, 0, 2'd2, 0, 32'hCAFE_F00D, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h40, 32'h0, 1, 0, 2'd2, 0, 32'h1, 0, 0, '0);
            checkVal("bp_addr", oDMEM_Address, 32'h20);
            checkVal("bp_ready", oReq_Ready, 0);
        end
        idle(1, 0, '0);
        checkVal("bp_release", oDMEM_Valid, 0);

        // Misaligned load word at 0x101
        cyc(1, 32'h101, 32'h0, 0, 1, 2'd2, 0, '0, 1, 0, '0);
`ifdef DEF_CP_LSU_MISALIGN_TRAP_EN
        checkVal("mis_pulse", oMisalign, 1);
        checkVal("mis_addr", oMisalign_Address, 32'h101);
        checkVal("mis_no_issue", oDMEM_Valid, 0);
`else
        checkVal("mis_aligned_addr", oDMEM_Address, 32'h100);
        checkVal("mis_aligned_bs", oDMEM_Byte_Select, 4'b1111);
        checkVal("mis_tied", oMisalign, 0);
`endif
        idle(1, 0, '0);
        idle(1, 1, 32'h0102_0304);

        // Randomized traffic with a reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) midReset();
            rv = ($urandom_range(0, 9) < 7);
            we = $urandom_range(0, 1);
            re = $urandom_range(0, 1);
            op = 2'($urandom_range(0, 3));
            sg = $urandom_range(0, 1);
            sd = $urandom;
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom; b = $urandom;
            end else begin
                a = $urandom_range(0, 'hFFF); b = $urandom_range(0, 15);
            end
            dr = ($urandom_range(0, 9) < 7);
            rd = $urandom;
            if (issuedOut > 0)        rdv = $urandom_range(0, 1);
            else if (ldq.size() == 0) rdv = ($urandom_range(0, 9) == 0);
            else                      rdv = 0;
            cyc(rv, a, b, we, re, op, sg, sd, dr, rdv, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
